// File: rtl/sync_mod_counter.sv
// ---------------------------------------------------------------------------
// sync_mod_counter
//
// Synchronous up/down counter with a programmable modulus, a parallel load,
// an enable prescaler, a terminal-count output and wrap flags. All state
// changes on the rising edge of one clock, so q never ripples and the
// registered outputs are glitch-free.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   MODULO    count range 0..MODULO-1, legal 2..2**WIDTH
//   PRESCALE  enabled cycles per count step, legal 1..65536 (1 = every cycle)
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous reset, active-low (0 = reset)
//   en        in   1      count enable, advances the prescaler when high
//   up        in   1      direction, 1 = increment, 0 = decrement
//   load      in   1      parallel load strobe (beats en)
//   load_val  in   WIDTH  value to load, clamped to MODULO-1
//   clr_ovf   in   1      clears the sticky ovf flag
//   q         out  WIDTH  counter value (register)
//   tc        out  1      terminal count for the current direction (comb.)
//   wrap      out  1      one-cycle pulse: the step just taken wrapped
//   ovf       out  1      sticky wrap flag
// ---------------------------------------------------------------------------
module sync_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // The prescaler counts 0..PRESCALE-1; a single bit is kept even when
  // PRESCALE==1 so the register always has a legal width.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] Q_ZERO   = '0;
  localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  // MODULO may equal 2**WIDTH, which does not fit in WIDTH bits, so the
  // load range test is made one bit wider.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

  logic [PRE_W-1:0] pre;
  logic             step;
  logic             at_end;
  logic             wrap_step;
  logic [WIDTH-1:0] q_step;

  // Loaded values at or above the modulus are clamped to the top count.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} < MOD_EXT)
      return v;
    else
      return Q_MAX;
  endfunction

  // Increment never computes past Q_MAX, so no carry out of WIDTH bits
  // occurs even when MODULO==2**WIDTH.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    if (v == Q_MAX)
      return Q_ZERO;
    else
      return v + Q_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    if (v == Q_ZERO)
      return Q_MAX;
    else
      return v - Q_ONE;
  endfunction

  // A step happens only on the enabled cycle that completes the prescale
  // period; load takes priority and suppresses it.
  always_comb begin
    step      = 1'b0;
    at_end    = 1'b0;
    wrap_step = 1'b0;
    q_step    = q;
    step      = !load && en && (pre == PRE_LAST);
    at_end    = up ? (q == Q_MAX) : (q == Q_ZERO);
    wrap_step = step && at_end;
    q_step    = up ? step_up(q) : step_down(q);
  end

  // Counter, prescaler and flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      pre  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (load) begin
        q   <= clamp_load(load_val);
        pre <= '0;
      end else if (en) begin
        if (pre == PRE_LAST) begin
          pre <= '0;
          q   <= q_step;
        end else begin
          pre <= pre + PRE_ONE;
        end
      end

      wrap <= wrap_step;

      // A wrap in the same cycle as a clear leaves the flag set.
      if (wrap_step)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  // Terminal count follows q and the live direction input.
  assign tc = up ? (q == Q_MAX) : (q == Q_ZERO);

endmodule
